// File: rtl/mdu_iterative_unit.sv
// mdu_iterative_unit: one-at-a-time RV32M multiply/divide engine for the
// execute stage. Shift-add multiply and restoring divide, one bit per cycle,
// with early completion for divide-by-zero and signed overflow.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; operands and sign flags latched on accept
// S_BUSY | one multiply/divide iteration per cycle, counter counts down
// S_DONE | result register holds the answer, result_valid pulses

module mdu_iterative_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state_q, state_d;
    logic [2:0]          fn_q;
    logic [XLEN-1:0]     mag_a_q, mag_b_q;
    logic                neg_q, sa_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     rem_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                load_start, load_iter, load_result;
    logic [XLEN-1:0]     result_d;

    logic                a_signed, b_signed, sa_in, sb_in;
    logic [XLEN-1:0]     mag_a_in, mag_b_in;
    logic                div_zero, div_ovf, early;
    logic [XLEN-1:0]     early_res;

    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       shifted;
    logic                ge;
    logic [XLEN-1:0]     sub;
    logic [2*XLEN-1:0]   acc_nx;
    logic [XLEN-1:0]     rem_nx;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo, rem;
    logic [XLEN-1:0]     final_res;

    // Operand decode: signedness, magnitudes and the early-out cases.
    always_comb begin
        a_signed  = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        sa_in     = a_signed & op_a[XLEN-1];
        sb_in     = b_signed & op_b[XLEN-1];
        mag_a_in  = sa_in ? (~op_a + 1'b1) : op_a;
        mag_b_in  = sb_in ? (~op_b + 1'b1) : op_b;
        div_zero  = funct3[2] && (op_b == '0);
        div_ovf   = funct3[2] && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
        early     = div_zero || div_ovf;
        // funct3[1] separates remainder from quotient for the divide group
        if (div_zero) early_res = funct3[1] ? op_a : '1;
        else          early_res = funct3[1] ? '0   : op_a;
    end

    // One iteration: shift-add step for multiply, restoring step for divide.
    // The low half of acc holds the unconsumed multiplier or the quotient.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
        shifted = {rem_q, acc_q[XLEN-1]};
        ge      = shifted >= {1'b0, mag_b_q};
        sub     = shifted[XLEN-1:0] - mag_b_q;
        if (fn_q[2]) begin
            acc_nx = {{XLEN{1'b0}}, acc_q[XLEN-2:0], ge};
            rem_nx = ge ? sub : shifted[XLEN-1:0];
        end else begin
            acc_nx = {mul_sum, acc_q[XLEN-1:1]};
            rem_nx = rem_q;
        end
    end

    // Sign correction and output select, taken from the last iteration's
    // values so the result register is loaded on the edge entering DONE.
    always_comb begin
        prod = neg_q ? (~acc_nx + 1'b1) : acc_nx;
        quo  = neg_q ? (~acc_nx[XLEN-1:0] + 1'b1) : acc_nx[XLEN-1:0];
        rem  = sa_q  ? (~rem_nx + 1'b1) : rem_nx;
        case (fn_q)
            3'b000:                 final_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quo;
            default:                final_res = rem;
        endcase
    end

    // Next-state and datapath enables; flush overrides everything but reset.
    always_comb begin
        state_d     = state_q;
        load_start  = 1'b0;
        load_iter   = 1'b0;
        load_result = 1'b0;
        result_d    = final_res;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_start = 1'b1;
                    if (early) begin
                        state_d     = S_DONE;
                        load_result = 1'b1;
                        result_d    = early_res;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                load_iter = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = S_DONE;
                    load_result = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d     = S_IDLE;
            load_start  = 1'b0;
            load_iter   = 1'b0;
            load_result = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Operand latch, iteration registers, down-counter and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            fn_q    <= '0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
            acc_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            result  <= '0;
        end else begin
            if (load_start) begin
                fn_q    <= funct3;
                mag_a_q <= mag_a_in;
                mag_b_q <= mag_b_in;
                neg_q   <= sa_in ^ sb_in;
                sa_q    <= sa_in;
                acc_q   <= funct3[2] ? {{XLEN{1'b0}}, mag_a_in} : {{XLEN{1'b0}}, mag_b_in};
                rem_q   <= '0;
                cnt_q   <= CNT_W'(XLEN);
            end
            if (load_iter) begin
                acc_q <= acc_nx;
                rem_q <= rem_nx;
                cnt_q <= cnt_q - 1'b1;
            end
            if (load_result) result <= result_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign result_valid = (state_q == S_DONE);

endmodule

// File: tb/tb_mdu_iterative_unit.sv
// Self-checking bench for mdu_iterative_unit (XLEN = 32): directed cases,
// flush/reset behaviour and randomized operations against an arithmetic model.

module tb_mdu_iterative_unit;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        busy, result_valid;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_exp = '0;

    mdu_iterative_unit dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .flush(flush), .busy(busy),
        .result_valid(result_valid), .result(result)
    );

    always #5 clk = ~clk;

    // Reference: RV32M semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(int'(a) / int'(b));
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(int'(a) % int'(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Drive one operation and observe: result at the valid pulse, cycle of the
    // pulse relative to the accepting edge, pulse count, and busy anomalies.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, output logic [31:0] res, output int lat,
                          output int pulses, output int busy_bad);
        @(negedge clk);
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        lat = 0; pulses = 0; busy_bad = 0; res = '0;
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (result_valid) begin
                pulses++;
                if (lat == 0) begin lat = c; res = result; start = 1'b0; end
            end
            if (lat == 0 && !busy) busy_bad++;
            if (lat != 0 && c == lat + 1 && busy) busy_bad++;
            if (lat != 0 && c >= lat + 3) break;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_state busy=%b valid=%b result=%h want 0/0/0", busy, result_valid, result);
        end
    endtask

    task automatic test_mul();
        logic [31:0] r; int lat, pul, bb;
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, r, lat, pul, bb);
        checks++;
        if (r !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_7x-3 got %h want FFFFFFEB", r); end
        checks++;
        if (lat !== 33 || pul !== 1) begin errors++; $display("FAIL mul_timing lat=%0d pulses=%0d want 33/1", lat, pul); end
        checks++;
        if (bb !== 0) begin errors++; $display("FAIL mul_busy anomalies=%0d want 0", bb); end
        last_exp = 32'hFFFF_FFEB;
    endtask

    task automatic test_mulh_variants();
        logic [31:0] r; int lat, pul, bb;
        logic [31:0] want [3] = '{32'h4000_0000, 32'hC000_0000, 32'h4000_0000};
        for (int i = 0; i < 3; i++) begin
            run_op(3'(i + 1), 32'h8000_0000, 32'h8000_0000, 1'b0, r, lat, pul, bb);
            checks++;
            if (r !== want[i] || lat !== 33) begin
                errors++;
                $display("FAIL mulh_f%0d got %h lat %0d want %h lat 33", i + 1, r, lat, want[i]);
            end
            last_exp = want[i];
        end
    endtask

    task automatic test_div_special();
        logic [31:0] r; int lat, pul, bb;
        logic [2:0]  fs [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] as [4] = '{32'd100, 32'd100, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ws [4] = '{32'hFFFF_FFFF, 32'd100, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 4; i++) begin
            run_op(fs[i], as[i], bs[i], 1'b0, r, lat, pul, bb);
            checks++;
            if (r !== ws[i] || lat !== 1 || pul !== 1 || bb !== 0) begin
                errors++;
                $display("FAIL div_early_%0d got %h lat %0d pulses %0d busybad %0d want %h lat 1", i, r, lat, pul, bb, ws[i]);
            end
            last_exp = ws[i];
        end
    endtask

    task automatic test_div_signed();
        logic [31:0] r; int lat, pul, bb;
        logic [2:0]  fs [3] = '{3'd4, 3'd6, 3'd7};
        logic [31:0] as [3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7};
        logic [31:0] ws [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1};
        for (int i = 0; i < 3; i++) begin
            run_op(fs[i], as[i], 32'd2, 1'b0, r, lat, pul, bb);
            checks++;
            if (r !== ws[i] || lat !== 33) begin
                errors++;
                $display("FAIL div_signed_%0d got %h lat %0d want %h lat 33", i, r, lat, ws[i]);
            end
            last_exp = ws[i];
        end
    endtask

    task automatic test_flush();
        logic [31:0] r; int lat, pul, bb; int seen;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (result_valid) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL flush_no_valid pulses=%0d want 0", seen); end
        checks++;
        if (result !== last_exp) begin errors++; $display("FAIL flush_result_hold got %h want %h", result, last_exp); end
        start = 1'b1; flush = 1'b1; funct3 = 3'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_beats_start busy=%b want 0", busy); end
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r, lat, pul, bb);
        checks++;
        if (r !== 32'hFFFF_FFFE || lat !== 33) begin
            errors++;
            $display("FAIL flush_then_mulhu got %h lat %0d want FFFFFFFE lat 33", r, lat);
        end
        last_exp = 32'hFFFF_FFFE;
    endtask

    task automatic test_start_held();
        logic [31:0] r, a, b, w; int lat, pul, bb;
        a = $urandom; b = $urandom;
        w = ref_model(3'd0, a, b);
        run_op(3'd0, a, b, 1'b1, r, lat, pul, bb);
        checks++;
        if (pul !== 1 || bb !== 0) begin errors++; $display("FAIL start_held pulses=%0d busybad=%0d want 1/0", pul, bb); end
        checks++;
        if (r !== w) begin errors++; $display("FAIL start_held_result got %h want %h", r, w); end
        last_exp = w;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; op_a = 32'd12345; op_b = 32'd678;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid busy=%b valid=%b result=%h want 0/0/0", busy, result_valid, result);
        end
        reset = 1'b0;
        @(negedge clk);
        last_exp = '0;
    endtask

    task automatic test_random();
        logic [31:0] r, a, b, w; logic [2:0] f; int lat, pul, bb, el;
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            w = ref_model(f, a, b);
            el = exp_lat(f, a, b);
            run_op(f, a, b, 1'b0, r, lat, pul, bb);
            checks++;
            if (r !== w || lat !== el || pul !== 1 || bb !== 0) begin
                errors++;
                $display("FAIL random_%0d f=%0d a=%h b=%h got %h lat %0d pulses %0d busybad %0d want %h lat %0d",
                         i, f, a, b, r, lat, pul, bb, w, el);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_mul();
        test_mulh_variants();
        test_div_special();
        test_div_signed();
        test_flush();
        test_start_held();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_iterative_unit.md
# mdu_iterative_unit

Iterative multiply/divide unit implementing the full RV32M funct3 space (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the execute stage. It is the parametrised, stateful successor to the combinational ALU operation decode. It accepts one operation at a time, raises `busy` so the hazard unit stalls the pipeline, and delivers a registered result with a one-cycle valid pulse. Divide-by-zero and signed overflow complete early, and a pipeline flush can abort an operation in flight.

## Interface
- `XLEN`, default 32: operand/result width; must be even and ≥ 8.
- `CNT_W`, default $clog2(XLEN)+1: iteration counter width (derived; not overridden).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `funct3`  in  3  RV32M operation select.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  XLEN  rs1 operand; sampled with `start`.
- `op_b`  in  XLEN  rs2 operand; sampled with `start`.
- `flush`  in  1  abort the current operation; synchronous.
- `busy`  out  1  high whenever state ≠ IDLE.
- `result_valid`  out  1  one-cycle pulse, high in DONE.
- `result`  out  XLEN  registered result; holds its value until the next completion or reset.

## Operation
- FSM states: IDLE, BUSY, DONE.
- Reset: state = IDLE; `busy`=0, `result_valid`=0, `result`=0; all internal registers cleared.
- Input priority each cycle: `reset` > `flush` > normal operation.

IDLE with `start`=1:
- Latch `funct3` and the operand magnitudes.
  - Signedness: a is signed for MULH, MULHSU, DIV, REM; b is signed for MULH, DIV, REM.
  - Latch the result-sign flags.
- Divide by zero (funct3[2]=1 and op_b=0): go to DONE, skipping BUSY.
  - Quotient = all-ones (DIV and DIVU).
  - Remainder = op_a (REM and REMU).
- Signed overflow (DIV/REM, op_a = 1<<(XLEN-1), op_b = all-ones): go to DONE.
  - Quotient = op_a.
  - Remainder = 0.
- Otherwise: go to BUSY with the counter set to XLEN.

IDLE with `start`=0:
- Remain in IDLE.

BUSY:
- Exactly one iteration per cycle; the counter decrements each cycle.
- When the counter reaches 0, go to DONE.
- Multiply: unsigned shift-add into a 2·XLEN accumulator, consuming |b| LSB first.
- Divide: unsigned restoring division, 1 quotient bit per cycle, with an XLEN+1-bit partial remainder.

DONE:
- Apply sign correction by two's complement.
  - Product is negated if sign(a)^sign(b), after the signedness masking above.
  - Quotient is negated if sign(a)^sign(b).
  - Remainder takes the sign of a.
- Select the output:
  - MUL: low XLEN bits of the product.
  - MULH, MULHSU, MULHU: high XLEN bits.
  - DIV, DIVU: quotient.
  - REM, REMU: remainder.
- Register the selected value into `result`, assert `result_valid`, and return to IDLE.

`start` handling:
- `start` asserted in BUSY or DONE is ignored, not queued.
- The pipeline holds the instruction while `busy`=1.

`flush`=1, in any state:
- Next state is IDLE; no `result_valid` follows; `result` is unchanged.
- `flush` together with `start` in IDLE: flush wins and the operation is not accepted.

## Timing
- Accepting `start` at edge T:
  - `busy` is high from T+1.
  - Normal op: BUSY for cycles T+1..T+XLEN, DONE at T+XLEN+1 with `result_valid`=1 and `result` valid in the same cycle.
  - Early-out op: DONE at T+1.
- `busy` falls in the cycle after DONE, so a new `start` can be accepted at T+XLEN+2 (normal) or T+2 (early-out).
- Flush asserted in cycle F: state = IDLE and `busy`=0 from F+1.
- Reset asserted mid-operation: all outputs at reset values from the next edge.
- No combinational path from any input to any output.

## Test plan
- MUL, op_a=7, op_b=0xFFFFFFFD (−3), `start` at T → `result`=0xFFFFFFEB, `result_valid` only at T+33, `busy` high T+1..T+33.
- MULH/MULHSU/MULHU with 0x80000000 × 0x80000000 → 0x40000000, 0xC0000000, 0x40000000 respectively.
- DIVU 100/0 → 0xFFFFFFFF at T+1; REM 100/0 → 100; DIV 0x80000000/0xFFFFFFFF → 0x80000000 at T+1; REM of the same operands → 0.
- DIV −7/2 → 0xFFFFFFFD (−3); REM −7/2 → 0xFFFFFFFF (−1); REMU 7/2 → 1.
- `flush` at T+5 of a DIVU → `busy`=0 at T+6, no `result_valid`, `result` keeps its prior value; then MULHU 0xFFFFFFFF×0xFFFFFFFF accepted → 0xFFFFFFFE.
- `reset` at T+10 of a MUL → all outputs 0 next cycle; `start` held during BUSY is ignored, checked by verifying exactly one `result_valid` pulse per accepted operation.
